dm_access_arbiter: RTL and testbench



---
 rtl/dm_arb_pkg.sv | 55 +++++
 rtl/rr_arb2.sv | 41 ++++
 rtl/dm_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Purpose : Shared definitions for the data-memory access arbiter. It holds the
//           requester size codes, the memory write codes, the controller state
//           encoding and two small decode helpers.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    // Access size codes as presented by the requesters and forwarded to the
    // memory's read-cut select.
    localparam logic [1:0] SZ_WORD    = 2'd0;
    localparam logic [1:0] SZ_BYTE    = 2'd1;
    localparam logic [1:0] SZ_HALF    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // Memory write codes. Code 3 is deliberately absent because the memory
    // does not define it.
    localparam logic [2:0] MW_NONE = 3'd0;
    localparam logic [2:0] MW_WORD = 3'd1;
    localparam logic [2:0] MW_BYTE = 3'd2;
    localparam logic [2:0] MW_HALF = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Map a store of a given size onto the memory write code. Loads and
    // unknown sizes never produce a write.
    function automatic logic [2:0] memWrCode(input logic wr, input logic [1:0] size);
        logic [2:0] code;
        code = MW_NONE;
        if (wr) begin
            case (size)
                SZ_WORD: code = MW_WORD;
                SZ_BYTE: code = MW_BYTE;
                SZ_HALF: code = MW_HALF;
                default: code = MW_NONE;
            endcase
        end
        return code;
    endfunction

    // The memory always touches four bytes starting at the address, so the
    // highest legal start address is three below the top of the window.
    function automatic logic accessIllegal(input logic [15:0] ad,
                                           input logic [1:0]  size,
                                           input logic [15:0] memBase,
                                           input logic [15:0] memTop);
        return (ad < memBase) || (ad > (memTop - 16'd3)) || (size == SZ_ILLEGAL);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Purpose : Two-way round-robin pick. A lone requester wins outright; when both
//           request, the port that did not win last time is chosen.
// Ports   : Clk     - clock
//           Reset   - asynchronous active-high reset (favours port 0)
//           req     - request vector, bit n = port n
//           update  - a grant was taken this cycle; remember the winner
//           gnt     - one-hot combinational pick (zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // Set when port 1 was the last winner. It resets set so that the very
    // first contended pick goes to port 0.
    logic lastWasOne_q;

    // Pure combinational pick; only the contended case consults the history.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = lastWasOne_q ? 2'b01 : 2'b10;
        end
    end

    // History only moves when the owner actually accepts a grant, so a
    // blocked cycle never shifts fairness.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lastWasOne_q <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            lastWasOne_q <= gnt[1];
        end
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// -----------------------------------------------------------------------------
// dm_access_arbiter
// Purpose : Shares the single data-memory port between the CPU load/store
//           stage (port 0) and the debug/loader (port 1). Each granted request
//           is range-checked, issued to memory for one cycle and completed
//           with a one-cycle Done pulse carrying read data or an error flag.
// Ports   : Clk, Reset           - clock, asynchronous active-high reset
//           Req/Wr/Size/Ad/WData - per-port request (0 and 1), held until Gnt
//           Gnt0/Gnt1            - combinational accept
//           Done0/Done1          - registered completion pulse
//           Err0/Err1            - qualifies Done, access rejected
//           RData                - load result, valid with Done
//           Ad/WrData/MemWr/DMcut_sel - registered memory controls
//           DM                   - memory read data, combinational from Ad
// -----------------------------------------------------------------------------
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter logic [15:0] MEM_BASE = 16'hff00,
    parameter logic [15:0] MEM_TOP  = 16'hffff
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Wr0,
    input  logic        Wr1,
    input  logic [1:0]  Size0,
    input  logic [1:0]  Size1,
    input  logic [15:0] Ad0,
    input  logic [15:0] Ad1,
    input  logic [31:0] WData0,
    input  logic [31:0] WData1,
    output logic        Gnt0,
    output logic        Gnt1,
    output logic        Done0,
    output logic        Done1,
    output logic        Err0,
    output logic        Err1,
    output logic [31:0] RData,
    output logic [15:0] Ad,
    output logic [31:0] WrData,
    output logic [2:0]  MemWr,
    output logic [1:0]  DMcut_sel,
    input  logic [31:0] DM
);

    state_e      state_q;
    logic        owner_q;
    logic        wr_q;
    logic        done0_q;
    logic        done1_q;
    logic        err0_q;
    logic        err1_q;
    logic [31:0] rData_q;
    logic [15:0] ad_q;
    logic [31:0] wrData_q;
    logic [2:0]  memWr_q;
    logic [1:0]  dmCutSel_q;

    logic [1:0]  rrGnt;
    logic [1:0]  gnt;
    logic        anyGnt;
    logic        selPort;
    logic        selWr;
    logic [1:0]  selSize;
    logic [15:0] selAd;
    logic [31:0] selWData;
    logic        reqErr_d;
    logic [2:0]  memWr_d;

    rr_arb2 u_rr_arb2 (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    ({Req1, Req0}),
        .update (anyGnt),
        .gnt    (rrGnt)
    );

    // Arbitration is open in IDLE and also in DONE, which lets a new access
    // start while the previous one is completing (one access every 2 cycles).
    always_comb begin
        gnt      = (state_q != ISSUE) ? rrGnt : 2'b00;
        anyGnt   = (gnt != 2'b00);
        selPort  = gnt[1];
        selWr    = selPort ? Wr1    : Wr0;
        selSize  = selPort ? Size1  : Size0;
        selAd    = selPort ? Ad1    : Ad0;
        selWData = selPort ? WData1 : WData0;
        reqErr_d = accessIllegal(selAd, selSize, MEM_BASE, MEM_TOP);
        memWr_d  = memWrCode(selWr, selSize);
    end

    // Controller FSM with all memory-side and completion outputs registered.
    // Pulsed outputs default to zero every cycle, so Done/Err/RData last one
    // cycle and MemWr is only non-zero during ISSUE. A rejected request skips
    // ISSUE entirely and never touches the memory address or write lines.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rData_q    <= 32'd0;
            ad_q       <= 16'd0;
            wrData_q   <= 32'd0;
            memWr_q    <= MW_NONE;
            dmCutSel_q <= 2'd0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rData_q <= 32'd0;
            memWr_q <= MW_NONE;
            case (state_q)
                IDLE, DONE: begin
                    if (anyGnt) begin
                        owner_q <= selPort;
                        wr_q    <= selWr;
                        if (reqErr_d) begin
                            done0_q <= ~selPort;
                            done1_q <= selPort;
                            err0_q  <= ~selPort;
                            err1_q  <= selPort;
                            state_q <= DONE;
                        end else begin
                            ad_q       <= selAd;
                            wrData_q   <= selWData;
                            dmCutSel_q <= selSize;
                            memWr_q    <= memWr_d;
                            state_q    <= ISSUE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    rData_q <= wr_q ? 32'd0 : DM;
                    done0_q <= ~owner_q;
                    done1_q <= owner_q;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Gnt0      = gnt[0];
    assign Gnt1      = gnt[1];
    assign Done0     = done0_q;
    assign Done1     = done1_q;
    assign Err0      = err0_q;
    assign Err1      = err1_q;
    assign RData     = rData_q;
    assign Ad        = ad_q;
    assign WrData    = wrData_q;
    assign MemWr     = memWr_q;
    assign DMcut_sel = dmCutSel_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_access_arbiter
// Purpose : Self-checking bench for dm_access_arbiter. A byte-array memory
//           model sits on the memory port; single-port accesses come from a
//           vector table, completions are matched against a queue of expected
//           Done events, and reset/contention are hand-written sequences.
// Ports   : none (top-level bench)
// -----------------------------------------------------------------------------
module tb_dm_access_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0, Req1, Wr0, Wr1;
    logic [1:0]  Size0, Size1;
    logic [15:0] Ad0, Ad1;
    logic [31:0] WData0, WData1;
    logic        Gnt0, Gnt1, Done0, Done1, Err0, Err1;
    logic [31:0] RData;
    logic [15:0] Ad;
    logic [31:0] WrData;
    logic [2:0]  MemWr;
    logic [1:0]  DMcut_sel;
    logic [31:0] DM;

    typedef struct {
        logic        port;
        logic        wr;
        logic [1:0]  size;
        logic [15:0] ad;
        logic [31:0] wdata;
        logic        expErr;
        logic [2:0]  expMemWr;
        logic [31:0] expRData;
    } vec_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    exp_t expQ [$];
    logic [7:0] mem [0:255];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dm_access_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req0      (Req0),
        .Req1      (Req1),
        .Wr0       (Wr0),
        .Wr1       (Wr1),
        .Size0     (Size0),
        .Size1     (Size1),
        .Ad0       (Ad0),
        .Ad1       (Ad1),
        .WData0    (WData0),
        .WData1    (WData1),
        .Gnt0      (Gnt0),
        .Gnt1      (Gnt1),
        .Done0     (Done0),
        .Done1     (Done1),
        .Err0      (Err0),
        .Err1      (Err1),
        .RData     (RData),
        .Ad        (Ad),
        .WrData    (WrData),
        .MemWr     (MemWr),
        .DMcut_sel (DMcut_sel),
        .DM        (DM)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Memory model: little-endian bytes, the low 8 address bits select the
    // location inside the populated window; reads always return four bytes.
    assign DM = {mem[Ad[7:0] + 8'd3], mem[Ad[7:0] + 8'd2],
                 mem[Ad[7:0] + 8'd1], mem[Ad[7:0]]};

    always @(posedge Clk) begin
        case (MemWr)
            3'd1: begin
                mem[Ad[7:0]]        <= WrData[7:0];
                mem[Ad[7:0] + 8'd1] <= WrData[15:8];
                mem[Ad[7:0] + 8'd2] <= WrData[23:16];
                mem[Ad[7:0] + 8'd3] <= WrData[31:24];
            end
            3'd2: mem[Ad[7:0]] <= WrData[7:0];
            3'd4: begin
                mem[Ad[7:0]]        <= WrData[7:0];
                mem[Ad[7:0] + 8'd1] <= WrData[15:8];
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every Done must match the oldest expected entry in
    // port, error flag, read data and the cycle it was due.
    always @(negedge Clk) begin
        exp_t e;
        if (Done0 || Done1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", {30'd0, Done1, Done0}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("done_port", {30'd0, Done1, Done0}, e.port ? 32'd2 : 32'd1);
                checkOutput("done_err", {30'd0, Err1, Err0},
                            e.err ? (e.port ? 32'd2 : 32'd1) : 32'd0);
                checkOutput("done_rdata", RData, e.rdata);
                checkOutput("done_cycle", cyc, e.cyc);
            end
        end else if (Err0 || Err1) begin
            checkOutput("err_without_done", {30'd0, Err1, Err0}, 32'd0);
        end
    end

    // Drive one request on its port, wait (bounded) for the grant, queue the
    // expected completion and check the memory-side controls in ISSUE and
    // the cycle after.
    task automatic applyStimulus(input vec_t v);
        int   waitCnt;
        logic got;
        exp_t e;
        @(negedge Clk);
        if (!v.port) begin
            Req0 = 1'b1; Wr0 = v.wr; Size0 = v.size; Ad0 = v.ad; WData0 = v.wdata;
        end else begin
            Req1 = 1'b1; Wr1 = v.wr; Size1 = v.size; Ad1 = v.ad; WData1 = v.wdata;
        end
        #1;
        waitCnt = 0;
        got = v.port ? Gnt1 : Gnt0;
        while (!got && waitCnt < 10) begin
            @(negedge Clk);
            #1;
            waitCnt++;
            got = v.port ? Gnt1 : Gnt0;
        end
        checkOutput("gnt_wait", waitCnt, 32'd0);
        if (!got) begin
            Req0 = 1'b0;
            Req1 = 1'b0;
            return;
        end
        checkOutput("gnt_other", {31'd0, v.port ? Gnt0 : Gnt1}, 32'd0);
        e.port  = v.port;
        e.err   = v.expErr;
        e.rdata = v.expRData;
        e.cyc   = cyc + (v.expErr ? 1 : 2);
        expQ.push_back(e);
        @(negedge Clk);
        Req0 = 1'b0;
        Req1 = 1'b0;
        checkOutput("memwr_issue", {29'd0, MemWr}, {29'd0, v.expMemWr});
        if (!v.expErr) begin
            checkOutput("ad_issue", {16'd0, Ad}, {16'd0, v.ad});
            checkOutput("wrdata_issue", WrData, v.wdata);
            checkOutput("cutsel_issue", {30'd0, DMcut_sel}, {30'd0, v.size});
        end
        @(negedge Clk);
        checkOutput("memwr_after", {29'd0, MemWr}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] expGnt;
        exp_t       e;

        Req0 = 0; Req1 = 0; Wr0 = 0; Wr1 = 0; Size0 = 0; Size1 = 0;
        Ad0 = 0; Ad1 = 0; WData0 = 0; WData1 = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //            port  wr    size   ad        wdata         err   memwr rdata
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 16'hff10, 32'h12345678, 1'b0, 3'd1, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 16'hff10, 32'hffffffff, 1'b0, 3'd0, 32'h12345678};
        vecs[2]  = '{1'b1, 1'b1, 2'd1, 16'hff20, 32'h000000ab, 1'b0, 3'd2, 32'h00000000};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 16'hff20, 32'h00000000, 1'b0, 3'd0, 32'h000000ab};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 16'hff30, 32'h0000beef, 1'b0, 3'd4, 32'h00000000};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'hff30, 32'h55555555, 1'b0, 3'd0, 32'h0000beef};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 16'hfffc, 32'hcafef00d, 1'b0, 3'd1, 32'h00000000};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 16'hfffc, 32'h00000000, 1'b0, 3'd0, 32'hcafef00d};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 16'hfffd, 32'h11111111, 1'b1, 3'd0, 32'h00000000};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 16'h0100, 32'h00000000, 1'b1, 3'd0, 32'h00000000};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 16'hff50, 32'h22222222, 1'b1, 3'd0, 32'h00000000};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 16'hffff, 32'h00000000, 1'b1, 3'd0, 32'h00000000};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 16'hff00, 32'h00000000, 1'b0, 3'd0, 32'h00000000};
        vecs[13] = '{1'b1, 1'b1, 2'd0, 16'hfeff, 32'h33333333, 1'b1, 3'd0, 32'h00000000};

        // Outputs during and just after reset
        #1;
        checkOutput("reset_memwr", {29'd0, MemWr}, 32'd0);
        checkOutput("reset_done", {28'd0, Err1, Err0, Done1, Done0}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkOutput("reset_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);
        checkOutput("reset_rdata", RData, 32'd0);
        checkOutput("reset_ad", {16'd0, Ad}, 32'd0);
        checkOutput("reset_wrdata", WrData, 32'd0);
        checkOutput("reset_cutsel", {30'd0, DMcut_sel}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset while a store is in ISSUE: write strobe drops at once, the
        // access never completes and memory stays untouched.
        @(negedge Clk);
        Req0 = 1'b1; Wr0 = 1'b1; Size0 = 2'd0; Ad0 = 16'hff40; WData0 = 32'hdeadbeef;
        #1;
        checkOutput("rst_gnt0", {31'd0, Gnt0}, 32'd1);
        @(negedge Clk);
        Req0 = 1'b0;
        checkOutput("rst_issue_memwr", {29'd0, MemWr}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("rst_async_memwr", {29'd0, MemWr}, 32'd0);
        checkOutput("rst_async_ad", {16'd0, Ad}, 32'd0);
        repeat (3) @(negedge Clk);
        checkOutput("rst_no_write", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'd0);
        Reset = 1'b0;

        // Both ports held: grants alternate 0,1,0,1 every other cycle, and
        // port 0 wins first because reset restored the pointer.
        @(negedge Clk);
        Req0 = 1'b1; Wr0 = 1'b0; Size0 = 2'd0; Ad0 = 16'hff10; WData0 = 32'h0;
        Req1 = 1'b1; Wr1 = 1'b0; Size1 = 2'd0; Ad1 = 16'hff20; WData1 = 32'h0;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k % 2 == 1)            expGnt = 2'b00;
            else if ((k / 2) % 2 == 0) expGnt = 2'b01;
            else                       expGnt = 2'b10;
            checkOutput($sformatf("contend_gnt_%0d", k), {30'd0, Gnt1, Gnt0}, {30'd0, expGnt});
            if (Gnt0 || Gnt1) begin
                e.port  = Gnt1;
                e.err   = 1'b0;
                e.rdata = Gnt1 ? 32'h000000ab : 32'h12345678;
                e.cyc   = cyc + 2;
                expQ.push_back(e);
            end
            @(negedge Clk);
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        repeat (5) @(negedge Clk);

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
